// File: rtl/hex8_disp_ctrl_pkg.sv
// Shared constants, state encoding and the double-dabble digit adjust for the
// 8-digit display controller.
package hex8_pkg;

  localparam logic [3:0]  CODE_BLANK = 4'hE;
  localparam logic [3:0]  CODE_F     = 4'hF;
  localparam logic [31:0] DISP_RESET = {8{CODE_BLANK}};
  localparam logic [31:0] DISP_OVF   = {8{CODE_F}};
  localparam logic [26:0] MAX_DEC    = 27'd99_999_999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  // Every BCD digit of 5 or more gets +3 so the following left shift carries correctly.
  function automatic logic [31:0] bcd_adjust(input logic [31:0] bcd);
    logic [31:0] res;
    res = bcd;
    for (int i = 0; i < 8; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/hex8_disp_ctrl_if.sv
// Request channels of the display controller: measurement and message sources,
// each a valid/ready handshake with its payload.
interface hex8_disp_ctrl_if #(
  parameter int BIN_W = 27
);
  logic             meas_valid;
  logic             meas_ready;
  logic [BIN_W-1:0] meas_bin;
  logic             msg_valid;
  logic             msg_ready;
  logic [31:0]      msg_code;

  modport master (
    output meas_valid, meas_bin, msg_valid, msg_code,
    input  meas_ready, msg_ready
  );

  modport slave (
    input  meas_valid, meas_bin, msg_valid, msg_code,
    output meas_ready, msg_ready
  );
endinterface

// File: rtl/hex8_disp_ctrl_bin2bcd.sv
// Sequential shift-add-3 binary to 8-digit BCD converter, MSB first, one bit per cycle.
// The first bit is taken on the start edge; done pulses the cycle after the last shift.
module bin2bcd_seq
  import hex8_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [31:0]      bcd,
  output logic             done
);

  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             active;
  logic [31:0]      adj;

  assign adj = bcd_adjust(bcd);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bcd     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd     <= {31'd0, bin[BIN_W-1]};
        shreg   <= bin << 1;
        bit_cnt <= CW'(1);
        active  <= 1'b1;
      end else if (active) begin
        bcd     <= {adj[30:0], shreg[BIN_W-1]};
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + CW'(1);
        if (bit_cnt == CW'(BIN_W - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hex8_disp_ctrl.sv
// Display controller: round-robin arbitration between measurement and message
// sources, BCD conversion, overflow and optional leading-zero blanking (HEX8_LZB_EN).
module hex8_disp_ctrl
  import hex8_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hex8_disp_ctrl_if.slave       req,
  output logic [DIGITS*4-1:0]   disp_data,
  output logic                  disp_en,
  output logic                  busy,
  output logic                  ovf
);

  state_t      state, next_state;
  logic        meas_acc, msg_acc, last_meas, ovf_pending, src_meas, conv_done;
  logic [31:0] msg_hold, conv_bcd, meas_digits;

  // Readies are forced low while Rst is high so nothing is accepted during reset.
  always_comb begin
    req.meas_ready = 1'b0;
    req.msg_ready  = 1'b0;
    if (state == IDLE && !Rst) begin
      if (req.meas_valid && (!req.msg_valid || !last_meas)) req.meas_ready = 1'b1;
      else if (req.msg_valid)                               req.msg_ready  = 1'b1;
    end
  end

  assign meas_acc = req.meas_valid & req.meas_ready;
  assign msg_acc  = req.msg_valid  & req.msg_ready;
  assign busy     = (state != IDLE);

  bin2bcd_seq #(.BIN_W(BIN_W)) u_bin2bcd (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (meas_acc),
    .bin   (req.meas_bin),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (meas_acc) next_state = CONV;
            else if (msg_acc) next_state = LOAD;
      CONV: if (conv_done) next_state = LOAD;
      LOAD: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= next_state;
  end

`ifdef HEX8_LZB_EN
  logic leading;
  always_comb begin
    meas_digits = conv_bcd;
    leading     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && conv_bcd[i*4 +: 4] == 4'h0) meas_digits[i*4 +: 4] = CODE_BLANK;
      else                                        leading = 1'b0;
    end
  end
`else
  assign meas_digits = conv_bcd;
`endif

  // Overflow is decided at accept so the conversion always takes the same time.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      disp_data   <= DISP_RESET;
      disp_en     <= 1'b0;
      ovf         <= 1'b0;
      last_meas   <= 1'b0;
      ovf_pending <= 1'b0;
      src_meas    <= 1'b0;
      msg_hold    <= '0;
    end else begin
      if (meas_acc) begin
        ovf_pending <= (32'(req.meas_bin) > 32'(MAX_DEC));
        src_meas    <= 1'b1;
        last_meas   <= 1'b1;
      end else if (msg_acc) begin
        msg_hold    <= req.msg_code;
        src_meas    <= 1'b0;
        last_meas   <= 1'b0;
      end
      if (state == LOAD) begin
        disp_en <= 1'b1;
        if (src_meas) begin
          disp_data <= ovf_pending ? DISP_OVF : meas_digits;
          ovf       <= ovf_pending;
        end else begin
          disp_data <= msg_hold;
        end
      end
    end
  end

endmodule
